ahb_bridge_32to64: RTL and testbench
====================================

Name: ahb_bridge_32to64

Overview:
- AHB-Lite width bridge placed directly upstream of the 64-bit SRAM slave.
- Accepts 32-bit AHB-Lite transfers from the CPU-side bus. Re-issues each one as a registered 64-bit AHB-Lite transfer on the slave side.
- Steers read data to the correct lane and replicates write data onto both lanes.
- Inserts one wait state per transfer, which isolates timing. Rejects illegal sizes with a two-cycle ERROR response.

Parameters:
- AW, 12, byte-address width on both sides (HADDR and M_HADDR).

Ports:
- HCLK  in  1  system bus clock
- HRESETn  in  1  system bus reset; asynchronous, active-low
- HSEL  in  1  upstream slave select
- HREADY  in  1  upstream ready input
- HTRANS  in  2  upstream transfer type
- HSIZE  in  3  upstream size
- HWRITE  in  1  upstream write flag
- HADDR  in  AW  upstream byte address
- HWDATA  in  32  upstream write data
- HREADYOUT  out  1  upstream ready output
- HRESP  out  2  upstream response (2'b00 OKAY, 2'b01 ERROR)
- HRDATA  out  32  upstream read data
- M_HSEL  out  1  downstream select
- M_HREADY  out  1  downstream HREADY; always equals M_HREADYOUT
- M_HTRANS  out  2  downstream transfer type
- M_HSIZE  out  3  downstream size
- M_HWRITE  out  1  downstream write flag
- M_HADDR  out  AW  downstream byte address
- M_HWDATA  out  64  downstream write data
- M_HREADYOUT  in  1  downstream ready
- M_HRESP  in  2  downstream response
- M_HRDATA  in  64  downstream read data

Behaviour:
- accept = HSEL & HREADY & HTRANS[1] & HREADYOUT. On accept, register HADDR, HSIZE and HWRITE into hold registers.
- Illegal transfer: HSIZE > 3'b010. See also the Optional Feature.
- FSM states: IDLE, ADDR, DATA, ERR1, ERR2.
- Reset values: state=IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, M_HSEL=0, M_HTRANS=00, M_HSIZE=0, M_HWRITE=0, M_HADDR=0. Hold registers reset to 0.
- IDLE:
  - HREADYOUT=1, HRESP=00.
  - accept & legal -> ADDR. accept & illegal -> ERR1. Otherwise stay in IDLE.
- ADDR:
  - M_HSEL=1, M_HTRANS=2'b10 (NONSEQ); M_HADDR, M_HSIZE, M_HWRITE come from the hold registers.
  - HREADYOUT=0.
  - M_HREADYOUT=1 -> DATA. Otherwise stay in ADDR, holding the address phase stable.
- DATA:
  - M_HTRANS=00, M_HSEL=0.
  - M_HWDATA={HWDATA,HWDATA}.
  - HREADYOUT=M_HREADYOUT, HRESP=M_HRESP. A downstream two-cycle ERROR is therefore passed through unchanged.
  - HRDATA = held HADDR[2] ? M_HRDATA[63:32] : M_HRDATA[31:0]. HRDATA=0 in every other state.
  - M_HREADYOUT=1: if accept in the same cycle -> ADDR (or ERR1 if illegal), else -> IDLE.
- ERR1: HREADYOUT=0, HRESP=01 -> ERR2.
- ERR2: HREADYOUT=1, HRESP=01. New accept is allowed in this cycle, with the same next-state rules as IDLE.
- Latency and throughput:
  - An upstream transfer completes 2 cycles after accept with zero downstream wait states.
  - Peak rate is one transfer per 2 cycles.
  - Each downstream wait state adds exactly one upstream wait state.
- Width rule: M_HSIZE equals the upstream HSIZE; byte lanes are selected downstream by M_HADDR[2:0]. The bridge never issues HSIZE=3'b011.
- Upstream HTRANS IDLE or BUSY is not forwarded, and HREADYOUT stays 1 in IDLE.
- Upstream HWDATA is held by the master while HREADYOUT=0. The bridge does not register write data.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous). The in-flight transfer is dropped.

Optional Feature:
- Macro: AHB_BRIDGE_ALIGN_CHK_EN.
- Defined: misaligned transfers are also illegal and get the ERR1/ERR2 response without forwarding. Misaligned means halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
- Undefined: misaligned transfers are forwarded unchanged.

Test Plan:
- Word write at 0x104, HWDATA=0xDEADBEEF -> downstream sees NONSEQ, M_HADDR=0x104, M_HSIZE=010 one cycle after accept; M_HWDATA=0xDEADBEEF_DEADBEEF; HREADYOUT low for exactly 1 cycle.
- Word read at 0x104 with M_HRDATA=0x11223344_55667788 -> HRDATA=0x11223344. The same read at 0x100 -> HRDATA=0x55667788.
- Back-to-back reads at 0x0, 0x8, 0x10 presented on each completing cycle -> 3 transfers in 6 cycles, correct lanes, no idle cycle in between.
- Upstream HSIZE=011 at 0x0 -> no downstream NONSEQ; HRESP=01 for 2 cycles with HREADYOUT 0 then 1.
- Downstream inserts 2 wait states, then a two-cycle ERROR -> upstream HREADYOUT low for 3 cycles, then HRESP=01 mirrors downstream over both error cycles.
- HRESETn pulsed low while in ADDR -> M_HTRANS=00 and HREADYOUT=1 immediately. With AHB_BRIDGE_ALIGN_CHK_EN, a word at 0x102 -> ERROR response and no downstream transfer.

Source files
------------

// File: rtl/ahb_bridge_32to64.sv
// ahb_bridge_32to64: re-issues 32-bit AHB-Lite transfers as registered 64-bit transfers, one wait state each.
// Define AHB_BRIDGE_ALIGN_CHK_EN to also reject misaligned halfword/word transfers with an ERROR response.
module ahb_bridge_32to64 #(
   parameter int AW = 12
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HSEL,
   input  logic          HREADY,
   input  logic [1:0]    HTRANS,
   input  logic [2:0]    HSIZE,
   input  logic          HWRITE,
   input  logic [AW-1:0] HADDR,
   input  logic [31:0]   HWDATA,
   output logic          HREADYOUT,
   output logic [1:0]    HRESP,
   output logic [31:0]   HRDATA,
   output logic          M_HSEL,
   output logic          M_HREADY,
   output logic [1:0]    M_HTRANS,
   output logic [2:0]    M_HSIZE,
   output logic          M_HWRITE,
   output logic [AW-1:0] M_HADDR,
   output logic [63:0]   M_HWDATA,
   input  logic          M_HREADYOUT,
   input  logic [1:0]    M_HRESP,
   input  logic [63:0]   M_HRDATA
);
   typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR1, ERR2} state_t;
   state_t state;
   logic accept, illegal, go, rdy_q, unused_ok, hwrite_q;
   logic [1:0] resp_q;
   logic [2:0] hsize_q;
   logic [AW-1:0] haddr_q;
   assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;
`ifdef AHB_BRIDGE_ALIGN_CHK_EN
   assign illegal = (HSIZE > 3'b010) | (HSIZE == 3'b001 & HADDR[0]) | (HSIZE == 3'b010 & |HADDR[1:0]);
`else
   assign illegal = HSIZE > 3'b010;
`endif
   assign go = accept & ~illegal;
   // the downstream data phase is passed straight through; every other state drives registered values
   assign HREADYOUT = (state == DATA) ? M_HREADYOUT : rdy_q;
   assign HRESP = (state == DATA) ? M_HRESP : resp_q;
   assign HRDATA = (state != DATA) ? '0 : haddr_q[2] ? M_HRDATA[63:32] : M_HRDATA[31:0];
   assign M_HREADY = M_HREADYOUT;
   assign M_HWDATA = {HWDATA, HWDATA};
   assign {M_HADDR, M_HSIZE, M_HWRITE} = {haddr_q, hsize_q, hwrite_q};
   assign unused_ok = HTRANS[0];
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= IDLE;
         rdy_q <= 1'b1;
         resp_q <= 2'b00;
         M_HSEL <= 1'b0;
         M_HTRANS <= 2'b00;
         haddr_q <= '0;
         hsize_q <= '0;
         hwrite_q <= 1'b0;
      end else begin
         if (accept) begin
            haddr_q <= HADDR;
            hsize_q <= HSIZE;
            hwrite_q <= HWRITE;
         end
         case (state)
            IDLE, ERR2, DATA: if (state != DATA || M_HREADYOUT) begin
               state <= go ? ADDR : accept ? ERR1 : IDLE;
               M_HSEL <= go;
               M_HTRANS <= go ? 2'b10 : 2'b00;
               rdy_q <= ~accept;
               resp_q <= {1'b0, accept & illegal};
            end
            ADDR: if (M_HREADYOUT) begin
               state <= DATA;
               M_HSEL <= 1'b0;
               M_HTRANS <= 2'b00;
            end
            ERR1: begin
               state <= ERR2;
               rdy_q <= 1'b1;
               resp_q <= 2'b01;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ahb_bridge_32to64.sv
// tb_ahb_bridge_32to64: directed vectors, multi-cycle corner sequences and random traffic
// checked against a byte-addressed memory model; honours AHB_BRIDGE_ALIGN_CHK_EN.
`timescale 1ns/1ps
module tb_ahb_bridge_32to64;
   localparam int AW = 12;
   logic HCLK = 0, HRESETn = 0;
   logic HSEL = 0, HREADY = 1, HWRITE = 0;
   logic [1:0] HTRANS = 0;
   logic [2:0] HSIZE = 0;
   logic [AW-1:0] HADDR = 0;
   logic [31:0] HWDATA = 0;
   logic HREADYOUT, M_HSEL, M_HREADY, M_HWRITE, M_HREADYOUT;
   logic [1:0] HRESP, M_HTRANS, M_HRESP;
   logic [31:0] HRDATA;
   logic [2:0] M_HSIZE;
   logic [AW-1:0] M_HADDR;
   logic [63:0] M_HWDATA, M_HRDATA;
   logic rnd = 0, d_ready = 1;
   logic [1:0] d_resp = 0;
   logic [63:0] d_rdata = 0;
   logic s_pend, s_wr;
   logic [1:0] s_wl;
   logic [2:0] s_sz;
   logic [AW-1:0] s_a;
   logic [63:0] s_rdata;
   logic [7:0] sm [1<<AW];
   logic [7:0] ref_m [1<<AW];
   int next_w = 0, n_fwd = 0;
   int n_cmp = 0, n_bad = 0;

   typedef struct {
      string nm;
      logic sel, rdy;
      logic [1:0] trans;
      logic [2:0] sz;
      logic wr;
      logic [AW-1:0] a;
      logic [31:0] wd;
      logic [63:0] srd;
      int kind;
      logic [31:0] exp_rd;
   } vec_t;

`ifdef AHB_BRIDGE_ALIGN_CHK_EN
   localparam int K102 = 2;
`else
   localparam int K102 = 1;
`endif

   ahb_bridge_32to64 #(.AW(AW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .M_HSEL(M_HSEL), .M_HREADY(M_HREADY), .M_HTRANS(M_HTRANS), .M_HSIZE(M_HSIZE),
      .M_HWRITE(M_HWRITE), .M_HADDR(M_HADDR), .M_HWDATA(M_HWDATA),
      .M_HREADYOUT(M_HREADYOUT), .M_HRESP(M_HRESP), .M_HRDATA(M_HRDATA)
   );

   always #5 HCLK = ~HCLK;

   // downstream: either driven directly by the sequences, or a 64-bit SRAM slave with chosen wait states
   assign M_HREADYOUT = rnd ? (!s_pend || s_wl == 0) : d_ready;
   assign M_HRESP = rnd ? 2'b00 : d_resp;
   assign M_HRDATA = rnd ? s_rdata : d_rdata;

   function automatic logic [63:0] rd64(input logic [AW-1:0] a);
      logic [63:0] v;
      for (int k = 0; k < 8; k++) v[8*k +: 8] = sm[{a[AW-1:3], 3'(k)}];
      return v;
   endfunction

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         s_pend <= 0;
         s_wl <= 0;
         for (int i = 0; i < (1<<AW); i++) sm[i] <= 8'h00;
      end else begin
         if (s_pend && s_wl != 0) s_wl <= s_wl - 2'd1;
         if (s_pend && s_wl == 0) begin
            s_pend <= 0;
            if (s_wr) for (int i = 0; i < 4; i++) if (i < (1 << s_sz)) sm[s_a + AW'(i)] <= M_HWDATA[8*((int'(s_a) + i) % 8) +: 8];
         end
         if (M_HSEL && M_HTRANS[1] && M_HREADY) begin
            s_pend <= 1;
            s_wl <= 2'(next_w);
            s_wr <= M_HWRITE;
            s_sz <= M_HSIZE;
            s_a <= M_HADDR;
            s_rdata <= rd64(M_HADDR);
            n_fwd <= n_fwd + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic xfer(input logic wr, input logic [2:0] sz, input logic [AW-1:0] a, input logic [31:0] wd,
                       output int n, output logic [1:0] r1, output logic [1:0] rl, output logic [31:0] rd);
      @(posedge HCLK); #1;
      HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz; HADDR = a;
      @(posedge HCLK); #1;
      HSEL = 0; HTRANS = 2'b00; HWDATA = wd;
      n = 0;
      r1 = 2'b00;
      do begin
         @(negedge HCLK);
         n++;
         if (n == 1) r1 = HRESP;
      end while (!HREADYOUT && n < 20);
      rl = HRESP;
      rd = HRDATA;
   endtask

   initial begin
      vec_t tbl[12];
      logic [5:0] sq_rdy, sq_resp, ex_rdy, ex_resp;
      logic [AW-1:0] ba [3];
      logic [63:0] br [3];
      int k, n, base, legal_n;
      logic [1:0] r1, rl;
      logic [31:0] rd, wd, ex;
      logic [2:0] sz;
      logic [AW-1:0] a;
      logic wr;
      tbl[0]  = '{"wr_w104", 1, 1, 2'b10, 3'd2, 1, 12'h104, 32'hDEADBEEF, 64'h0, 1, 32'h0};
      tbl[1]  = '{"rd_w104", 1, 1, 2'b10, 3'd2, 0, 12'h104, 32'h0, 64'h11223344_55667788, 1, 32'h11223344};
      tbl[2]  = '{"rd_w100", 1, 1, 2'b10, 3'd2, 0, 12'h100, 32'h0, 64'h11223344_55667788, 1, 32'h55667788};
      tbl[3]  = '{"rd_b10f", 1, 1, 2'b10, 3'd0, 0, 12'h10F, 32'h0, 64'h11223344_55667788, 1, 32'h11223344};
      tbl[4]  = '{"wr_h0a2", 1, 1, 2'b10, 3'd1, 1, 12'h0A2, 32'hCAFE0000, 64'h0, 1, 32'h0};
      tbl[5]  = '{"sz3_err", 1, 1, 2'b10, 3'd3, 0, 12'h000, 32'h0, 64'h0, 2, 32'h0};
      tbl[6]  = '{"sz7_seq", 1, 1, 2'b11, 3'd7, 1, 12'h040, 32'h1234, 64'h0, 2, 32'h0};
      tbl[7]  = '{"nosel", 0, 1, 2'b10, 3'd2, 0, 12'h100, 32'h0, 64'h0, 0, 32'h0};
      tbl[8]  = '{"busy", 1, 1, 2'b01, 3'd2, 0, 12'h100, 32'h0, 64'h0, 0, 32'h0};
      tbl[9]  = '{"noready", 1, 0, 2'b10, 3'd2, 0, 12'h100, 32'h0, 64'h0, 0, 32'h0};
      tbl[10] = '{"rd_w102", 1, 1, 2'b10, 3'd2, 0, 12'h102, 32'h0, 64'h11223344_55667788, K102, 32'h55667788};
      tbl[11] = '{"rd_bfff", 1, 1, 2'b10, 3'd0, 0, 12'hFFF, 32'h0, 64'hAABBCCDD_00112233, 1, 32'hAABBCCDD};
      repeat (2) @(negedge HCLK);
      chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
      chk("rst_hresp", 64'(HRESP), 64'd0);
      chk("rst_hrdata", 64'(HRDATA), 64'd0);
      chk("rst_m_hsel", 64'(M_HSEL), 64'd0);
      chk("rst_m_htrans", 64'(M_HTRANS), 64'd0);
      chk("rst_m_haddr", 64'(M_HADDR), 64'd0);
      chk("rst_m_hsize", 64'(M_HSIZE), 64'd0);
      chk("rst_m_hwrite", 64'(M_HWRITE), 64'd0);
      chk("rst_m_hready", 64'(M_HREADY), 64'(M_HREADYOUT));
      HRESETn = 1;
      foreach (tbl[i]) begin
         @(posedge HCLK); #1;
         HSEL = tbl[i].sel; HREADY = tbl[i].rdy; HTRANS = tbl[i].trans; HSIZE = tbl[i].sz;
         HWRITE = tbl[i].wr; HADDR = tbl[i].a; d_rdata = tbl[i].srd; d_ready = 1; d_resp = 0;
         @(posedge HCLK); #1;
         HSEL = 0; HREADY = 1; HTRANS = 2'b00; HWDATA = tbl[i].wd;
         @(negedge HCLK);
         k = tbl[i].kind;
         chk($sformatf("%s/c1_ready", tbl[i].nm), 64'(HREADYOUT), 64'(k == 0));
         chk($sformatf("%s/c1_resp", tbl[i].nm), 64'(HRESP), 64'(k == 2));
         chk($sformatf("%s/c1_m_htrans", tbl[i].nm), 64'(M_HTRANS), (k == 1) ? 64'd2 : 64'd0);
         if (k == 1) begin
            chk($sformatf("%s/m_haddr", tbl[i].nm), 64'(M_HADDR), 64'(tbl[i].a));
            chk($sformatf("%s/m_hsize", tbl[i].nm), 64'(M_HSIZE), 64'(tbl[i].sz));
            chk($sformatf("%s/m_hwrite", tbl[i].nm), 64'(M_HWRITE), 64'(tbl[i].wr));
         end
         @(negedge HCLK);
         chk($sformatf("%s/c2_ready", tbl[i].nm), 64'(HREADYOUT), 64'd1);
         chk($sformatf("%s/c2_resp", tbl[i].nm), 64'(HRESP), 64'(k == 2));
         chk($sformatf("%s/c2_m_htrans", tbl[i].nm), 64'(M_HTRANS), 64'd0);
         if (k == 1) chk($sformatf("%s/data", tbl[i].nm), tbl[i].wr ? M_HWDATA : 64'(HRDATA),
                         tbl[i].wr ? {tbl[i].wd, tbl[i].wd} : 64'(tbl[i].exp_rd));
      end
      // back-to-back reads: next address presented on each completing cycle
      ba[0] = 12'h000; ba[1] = 12'h008; ba[2] = 12'h010;
      for (int i = 0; i < 3; i++) br[i] = {32'hF000_0000 + 32'(i), 32'h0A00_0000 + 32'(i)};
      HWRITE = 0; HSIZE = 3'd2;
      for (int i = 0; i < 3; i++) begin
         @(posedge HCLK); #1;
         HSEL = 1; HTRANS = 2'b10; HADDR = ba[i];
         @(negedge HCLK);
         if (i > 0) begin
            chk($sformatf("b2b%0d/ready", i - 1), 64'(HREADYOUT), 64'd1);
            chk($sformatf("b2b%0d/hrdata", i - 1), 64'(HRDATA), 64'(br[i-1][31:0]));
         end
         @(posedge HCLK); #1;
         d_rdata = br[i];
         @(negedge HCLK);
         chk($sformatf("b2b%0d/wait", i), 64'(HREADYOUT), 64'd0);
         chk($sformatf("b2b%0d/m_htrans", i), 64'(M_HTRANS), 64'd2);
         chk($sformatf("b2b%0d/m_haddr", i), 64'(M_HADDR), 64'(ba[i]));
      end
      @(posedge HCLK); #1;
      HSEL = 0; HTRANS = 2'b00;
      @(negedge HCLK);
      chk("b2b2/ready", 64'(HREADYOUT), 64'd1);
      chk("b2b2/hrdata", 64'(HRDATA), 64'(br[2][31:0]));
      @(negedge HCLK);
      chk("b2b/idle_after", 64'(M_HTRANS), 64'd0);
      // two downstream wait states then a two-cycle ERROR
      sq_rdy = 6'b110001; sq_resp = 6'b011000; ex_rdy = 6'b110000; ex_resp = 6'b011000;
      @(posedge HCLK); #1;
      HSEL = 1; HTRANS = 2'b10; HADDR = 12'h100; HWRITE = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge HCLK); #1;
         HSEL = 0; HTRANS = 2'b00; d_ready = sq_rdy[c]; d_resp = {1'b0, sq_resp[c]};
         @(negedge HCLK);
         chk($sformatf("werr%0d/ready", c), 64'(HREADYOUT), 64'(ex_rdy[c]));
         chk($sformatf("werr%0d/resp", c), 64'(HRESP), 64'(ex_resp[c]));
      end
      d_ready = 1; d_resp = 0;
      // asynchronous reset while the downstream address phase is pending
      @(posedge HCLK); #1;
      HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 12'h020;
      @(posedge HCLK); #1;
      HSEL = 0; HTRANS = 2'b00; d_ready = 0;
      @(negedge HCLK);
      chk("rst_mid/pre_htrans", 64'(M_HTRANS), 64'd2);
      #1 HRESETn = 0;
      #1;
      chk("rst_mid/m_htrans", 64'(M_HTRANS), 64'd0);
      chk("rst_mid/hreadyout", 64'(HREADYOUT), 64'd1);
      chk("rst_mid/m_hsel", 64'(M_HSEL), 64'd0);
      chk("rst_mid/m_haddr", 64'(M_HADDR), 64'd0);
      #1 HRESETn = 1; d_ready = 1;
      @(negedge HCLK);
      chk("rst_mid/dropped", 64'(M_HTRANS), 64'd0);
      chk("rst_mid/ready_after", 64'(HREADYOUT), 64'd1);
      // random traffic against the SRAM slave and a byte-memory reference
      rnd = 1;
      for (int i = 0; i < (1<<AW); i++) ref_m[i] = 8'h00;
      @(negedge HCLK); HRESETn = 0;
      @(negedge HCLK); HRESETn = 1;
      base = n_fwd;
      legal_n = 0;
      repeat (300) begin
         wr = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         a = AW'($urandom_range(0, 63)) | (($urandom_range(0, 1) == 1) ? 12'hFC0 : 12'h000);
         if (sz <= 2) a = a & ~AW'((1 << sz) - 1);
         wd = $urandom;
         next_w = $urandom_range(0, 2);
         for (int j = 0; j < 4; j++) ex[8*j +: 8] = ref_m[{a[AW-1:2], 2'(j)}];
         xfer(wr, sz, a, wd, n, r1, rl, rd);
         if (sz <= 2) begin
            legal_n++;
            chk($sformatf("rnd a=%h sz=%0d/cycles", a, sz), 64'(n), 64'(2 + next_w));
            chk($sformatf("rnd a=%h sz=%0d/resp", a, sz), 64'(rl), 64'd0);
            if (wr) for (int j = 0; j < (1 << sz); j++) ref_m[a + AW'(j)] = wd[8*((int'(a) + j) % 4) +: 8];
            else chk($sformatf("rnd a=%h sz=%0d/hrdata", a, sz), 64'(rd), 64'(ex));
         end else begin
            chk($sformatf("rnd_err a=%h sz=%0d/cycles", a, sz), 64'(n), 64'd2);
            chk($sformatf("rnd_err a=%h sz=%0d/resp1", a, sz), 64'(r1), 64'd1);
            chk($sformatf("rnd_err a=%h sz=%0d/resp2", a, sz), 64'(rl), 64'd1);
         end
      end
      @(negedge HCLK);
      chk("rnd/forwarded_count", 64'(n_fwd - base), 64'(legal_n));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
